// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - loads imem/dmem images, runs the CPU for N cycles, dumps a dmem window
module mem_loader #(
    parameter int CNT_W = 10,
    parameter int RUN_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] dump_words,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_CAP,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_imem_words;
    logic [CNT_W-1:0] r_dmem_words;
    logic [CNT_W-1:0] r_dump_words;
    logic [RUN_W-1:0] r_run_cycles;
    logic [RUN_W-1:0] r_run_cnt;
    logic [RUN_W-1:0] w_run_load;
    logic [63:0]      r_out_data;
    logic             w_accept_start;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_last_i;
    logic             w_last_d;
    logic             w_last_dump;
    logic [63:0]      w_addr_i;
    logic [63:0]      w_addr_d;

    assign w_accept_start = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_in_hs        = in_valid && in_ready;
    assign w_out_hs       = out_valid && out_ready;
    assign w_last_i       = (r_idx == r_imem_words - CNT_ONE);
    assign w_last_d       = (r_idx == r_dmem_words - CNT_ONE);
    assign w_last_dump    = (r_idx == r_dump_words - CNT_ONE);
    assign w_addr_i       = {{(64-CNT_W-2){1'b0}}, r_idx, 2'b00};
    assign w_addr_d       = {{(64-CNT_W-3){1'b0}}, r_idx, 3'b000};

    // A RUN entered straight from IDLE/DONE must see the count being latched this cycle.
    assign w_run_load = w_accept_start ? run_cycles : r_run_cycles;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (imem_words != '0)      w_next = S_LOAD_I;
                    else if (dmem_words != '0) w_next = S_LOAD_D;
                    else                       w_next = S_RUN;
                end
            end
            S_LOAD_I: begin
                if (w_in_hs && w_last_i) begin
                    w_next = (r_dmem_words != '0) ? S_LOAD_D : S_RUN;
                end
            end
            S_LOAD_D: begin
                if (w_in_hs && w_last_d) w_next = S_RUN;
            end
            S_RUN: begin
                if (r_run_cnt <= RUN_ONE) begin
                    w_next = (r_dump_words != '0) ? S_DUMP_RD : S_DONE;
                end
            end
            S_DUMP_RD:  w_next = S_DUMP_CAP;
            S_DUMP_CAP: w_next = S_DUMP_OUT;
            S_DUMP_OUT: begin
                if (out_ready) w_next = w_last_dump ? S_DONE : S_DUMP_RD;
            end
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_idx        <= '0;
            r_imem_words <= '0;
            r_dmem_words <= '0;
            r_dump_words <= '0;
            r_run_cycles <= '0;
            r_run_cnt    <= '0;
            r_out_data   <= '0;
        end else begin
            if (w_accept_start) begin
                r_imem_words <= imem_words;
                r_dmem_words <= dmem_words;
                r_dump_words <= dump_words;
                r_run_cycles <= run_cycles;
                r_idx        <= '0;
            end else if (r_state == S_LOAD_I && w_in_hs) begin
                r_idx <= w_last_i ? '0 : r_idx + CNT_ONE;
            end else if (r_state == S_LOAD_D && w_in_hs) begin
                r_idx <= w_last_d ? '0 : r_idx + CNT_ONE;
            end else if (r_state == S_DUMP_OUT && w_out_hs) begin
                r_idx <= r_idx + CNT_ONE;
            end

            if (w_next == S_RUN && r_state != S_RUN) begin
                r_run_cnt <= w_run_load;
            end else if (r_state == S_RUN && r_run_cnt != '0) begin
                r_run_cnt <= r_run_cnt - RUN_ONE;
            end

            if (r_state == S_DUMP_CAP) r_out_data <= rdata_ext_2;
        end
    end

    // Strobes are purely combinational from state and handshake; addresses idle at zero.
    assign busy        = !(r_state == S_IDLE || r_state == S_DONE);
    assign done        = (r_state == S_DONE);
    assign in_ready    = (r_state == S_LOAD_I) || (r_state == S_LOAD_D);
    assign cpu_enable  = (r_state == S_RUN) && (r_run_cnt != '0);
    assign out_valid   = (r_state == S_DUMP_OUT);
    assign out_data    = r_out_data;

    assign wen_ext     = (r_state == S_LOAD_I) && in_valid;
    assign ren_ext     = 1'b0;
    assign addr_ext    = (r_state == S_LOAD_I) ? w_addr_i : 64'd0;
    assign wdata_ext   = (r_state == S_LOAD_I) ? in_data[31:0] : 32'd0;

    assign wen_ext_2   = (r_state == S_LOAD_D) && in_valid;
    assign ren_ext_2   = (r_state == S_DUMP_RD);
    assign addr_ext_2  = (r_state == S_LOAD_D || r_state == S_DUMP_RD) ? w_addr_d : 64'd0;
    assign wdata_ext_2 = (r_state == S_LOAD_D) ? in_data : 64'd0;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader
module tb_mem_loader;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [9:0]  imem_words;
    logic [9:0]  dmem_words;
    logic [31:0] run_cycles;
    logic [9:0]  dump_words;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic        done;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    mem_loader #(.CNT_W(10), .RUN_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words),
        .run_cycles(run_cycles), .dump_words(dump_words),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory stand-in: synchronous write, one-cycle read latency.
    logic [63:0] dmem [0:31];
    logic [63:0] rdata_q;
    assign rdata_ext_2 = rdata_q;
    always @(posedge clk) begin
        if (wen_ext_2) dmem[addr_ext_2[7:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_q <= dmem[addr_ext_2[7:3]];
    end

    int n_cmp = 0;
    int n_err = 0;

    int          n_wi, n_wd, n_en, n_hs, n_bad, widx, bp_left;
    logic [63:0] wi_addr [0:15];
    logic [31:0] wi_data [0:15];
    logic [63:0] wd_addr [0:15];
    logic [63:0] wd_data [0:15];
    logic [63:0] hs_data [0:15];
    logic        prev_hold;
    logic [63:0] prev_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int k);
        return {32'hD000_0000 + k, 32'hC0DE_0000 + k};
    endfunction

    // One clock: observe mid-cycle, then return 1 ns after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (wen_ext && n_wi < 16) begin
            wi_addr[n_wi] = addr_ext; wi_data[n_wi] = wdata_ext; n_wi++;
        end
        if (wen_ext_2 && n_wd < 16) begin
            wd_addr[n_wd] = addr_ext_2; wd_data[n_wd] = wdata_ext_2; n_wd++;
        end
        if ((wen_ext || wen_ext_2) && !in_valid) n_bad++;
        if ((wen_ext || ren_ext || wen_ext_2 || ren_ext_2) && cpu_enable) n_bad++;
        if ((wen_ext_2 && ren_ext_2) || ren_ext) n_bad++;
        if (cpu_enable) n_en++;
        if (in_valid && in_ready) widx++;
        if (out_valid) begin
            if (prev_hold && out_data !== prev_data) n_bad++;
            if (out_ready) begin
                if (n_hs < 16) hs_data[n_hs] = out_data;
                n_hs++;
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                prev_data = out_data;
                if (bp_left > 0) bp_left--;
            end
        end else begin
            prev_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int ni, input int nd, input int nr, input int nu);
        imem_words = 10'(ni); dmem_words = 10'(nd);
        run_cycles = 32'(nr); dump_words = 10'(nu);
        n_wi = 0; n_wd = 0; n_en = 0; n_hs = 0; n_bad = 0; widx = 0;
        prev_hold = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_flow(input int ni, input int nd, input int nr, input int nu,
                            input bit gaps, input int bp, input bit poke);
        int  cyc;
        bit  tog;
        bit  poked;
        do_start(ni, nd, nr, nu);
        bp_left = bp; cyc = 0; tog = 1'b1; poked = 1'b0;
        while (!done && cyc < 2000) begin
            in_valid  = gaps ? tog : 1'b1;
            tog       = !tog;
            in_data   = word_of(widx);
            out_ready = (bp_left == 0);
            if (poke && !poked && n_wd == 1) begin
                start = 1'b1; imem_words = 10'd7; dmem_words = 10'd7;
                run_cycles = 32'd7; dump_words = 10'd7; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flow_done", {63'd0, done}, 64'd1);
    endtask

    task automatic check_full_flow(input string tag);
        check({tag, "_nwi"}, n_wi, 4);
        for (int j = 0; j < 4; j++) begin
            check({tag, "_wi_addr"}, wi_addr[j], 64'(4 * j));
            check({tag, "_wi_data"}, {32'd0, wi_data[j]}, {32'd0, 32'hC0DE_0000 + j});
        end
        check({tag, "_nwd"}, n_wd, 2);
        check({tag, "_wd_addr1"}, wd_addr[1], 64'd8);
        check({tag, "_wd_data1"}, wd_data[1], word_of(5));
        check({tag, "_en_cycles"}, n_en, 10);
        check({tag, "_nhs"}, n_hs, 2);
        check({tag, "_dump0"}, hs_data[0], word_of(4));
        check({tag, "_dump1"}, hs_data[1], word_of(5));
        check({tag, "_bad"}, n_bad, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {55'd0, in_ready, out_valid, busy, done, cpu_enable,
                              wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'd0);
        check({tag, "_addr"}, addr_ext | addr_ext_2, 64'd0);
        check({tag, "_data"}, {32'd0, wdata_ext} | wdata_ext_2 | out_data, 64'd0);
    endtask

    initial begin
        int cyc;
        arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        imem_words = '0; dmem_words = '0; run_cycles = '0; dump_words = '0;
        n_wi = 0; n_wd = 0; n_en = 0; n_hs = 0; n_bad = 0; widx = 0; bp_left = 0;
        prev_hold = 1'b0; prev_data = '0;
        step(); step();
        check_all_zero("reset");
        arst_n = 1'b1;
        step();

        // Full flow, including start->LOAD_I/busy latency.
        do_start(4, 2, 10, 2);
        check("start_busy", {62'd0, busy, in_ready}, 64'd3);
        bp_left = 0; cyc = 0;
        while (!done && cyc < 2000) begin
            in_valid = 1'b1; in_data = word_of(widx); out_ready = 1'b1;
            step(); cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("full_done", {63'd0, done}, 64'd1);
        check_full_flow("full");

        // Alternating input gaps.
        run_flow(3, 2, 2, 1, 1'b1, 0, 1'b0);
        check("gap_nwi", n_wi, 3);
        check("gap_wi_data2", {32'd0, wi_data[2]}, 64'hC0DE_0002);
        check("gap_nwd", n_wd, 2);
        check("gap_wd_data0", wd_data[0], word_of(3));
        check("gap_wd_data1", wd_data[1], word_of(4));
        check("gap_dump0", hs_data[0], word_of(3));
        check("gap_bad", n_bad, 0);

        // Output backpressure.
        run_flow(0, 3, 1, 3, 1'b0, 5, 1'b0);
        check("bp_nwi", n_wi, 0);
        check("bp_nhs", n_hs, 3);
        check("bp_dump2", hs_data[2], word_of(2));
        check("bp_en", n_en, 1);
        check("bp_bad", n_bad, 0);

        // Zero imem count.
        run_flow(0, 1, 0, 0, 1'b0, 0, 1'b0);
        check("z_nwi", n_wi, 0);
        check("z_nwd", n_wd, 1);
        check("z_wd_addr0", wd_addr[0], 64'd0);

        // All counts zero: one RUN cycle without enable, then DONE.
        do_start(0, 0, 0, 0);
        check("zero_t1", {61'd0, busy, done, cpu_enable}, 64'b100);
        step();
        check("zero_t2", {62'd0, busy, done}, 64'b01);

        // Reset while in RUN.
        do_start(2, 1, 20, 2);
        cyc = 0;
        while (!cpu_enable && cyc < 100) begin
            in_valid = 1'b1; in_data = word_of(widx); step(); cyc++;
        end
        in_valid = 1'b0;
        check("rrun_reached", {63'd0, cpu_enable}, 64'd1);
        arst_n = 1'b0;
        #1;
        check_all_zero("rst_run");
        step();
        arst_n = 1'b1;
        run_flow(4, 2, 10, 2, 1'b0, 0, 1'b0);
        check_full_flow("after_rrun");

        // Reset while in DUMP_OUT.
        do_start(0, 1, 0, 1);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            in_valid = 1'b1; in_data = word_of(widx); out_ready = 1'b0; step(); cyc++;
        end
        in_valid = 1'b0;
        check("rdump_reached", {63'd0, out_valid}, 64'd1);
        arst_n = 1'b0;
        #1;
        check_all_zero("rst_dump");
        step();
        arst_n = 1'b1;
        run_flow(4, 2, 10, 2, 1'b0, 0, 1'b0);
        check_full_flow("after_rdump");

        // Start pulsed during LOAD_D must be ignored.
        run_flow(2, 3, 1, 1, 1'b0, 0, 1'b1);
        check("busy_nwi", n_wi, 2);
        check("busy_nwd", n_wd, 3);
        check("busy_wd_addr2", wd_addr[2], 64'd16);
        check("busy_wd_data2", wd_data[2], word_of(4));
        check("busy_en", n_en, 1);
        check("busy_nhs", n_hs, 1);
        check("busy_dump0", hs_data[0], word_of(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
